// File: rtl/frame_seq_ctrl_pkg.sv
// Shared types and helpers for the frame-boundary controller.
// Box edges are COORD_W bits wide; centres and distances carry one extra bit.
package frame_seq_ctrl_pkg;

  localparam int COORD_W = 13;

  typedef struct packed {
    logic [COORD_W-1:0] t;
    logic [COORD_W-1:0] b;
    logic [COORD_W-1:0] l;
    logic [COORD_W-1:0] r;
  } box_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic box_empty(input box_t bx);
    return (bx.t > bx.b) || (bx.l > bx.r);
  endfunction

  function automatic logic [COORD_W:0] centre(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return {1'b0, sum[COORD_W:1]};
  endfunction

  function automatic logic [COORD_W-1:0] avg_round(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{COORD_W{1'b0}}, 1'b1};
    return sum[COORD_W:1];
  endfunction

  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W:0] a,
                                                input logic [COORD_W:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/frame_seq_ctrl_cfg_sync.sv
// Two-flop synchronizer for the asynchronous board switches.
module frame_seq_ctrl_cfg_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;

  // metastability chain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_r <= {W{1'b0}};
      q      <= {W{1'b0}};
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame-boundary controller: vsync-aligned switch config, window enable, box capture and stability.
// Define FRAME_SEQ_CTRL_SMOOTH_EN to load the rounded average of the previous and new box.
module frame_seq_ctrl
  import frame_seq_ctrl_pkg::*;
#(
  parameter logic [3:0]  THRESH_RST    = 4'd8,
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned MOVE_TOL      = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               vs_ni,
  input  logic               sw_filter_en,
  input  logic               sw_rect_en,
  input  logic [3:0]         sw_threshold,
  input  logic [COORD_W-1:0] box_t_i,
  input  logic [COORD_W-1:0] box_b_i,
  input  logic [COORD_W-1:0] box_l_i,
  input  logic [COORD_W-1:0] box_r_i,
  output logic               en_o,
  output logic               filter_en_o,
  output logic               rect_en_o,
  output logic [3:0]         threshold_o,
  output logic               sync_o,
  output logic               box_valid,
  input  logic               box_ready,
  output logic [COORD_W-1:0] box_t,
  output logic [COORD_W-1:0] box_b,
  output logic [COORD_W-1:0] box_l,
  output logic [COORD_W-1:0] box_r,
  output logic               box_stable,
  output logic [7:0]         drop_cnt,
  output logic [15:0]        frame_cnt
);

  localparam logic [3:0]       STABLE_C = 4'(STABLE_FRAMES);
  localparam logic [COORD_W:0] TOL_C    = (COORD_W+1)'(MOVE_TOL);

  logic [5:0]                 sw_sync_s;
  logic                       vs_d_r;
  logic                       vs_fall_s;
  logic                       eval_r;
  state_t                     state_r;
  state_t                     state_nx_s;
  frame_seq_ctrl_pkg::box_t   in_s;
  frame_seq_ctrl_pkg::box_t   load_box_s;
  logic                       empty_s;
  logic                       load_s;
  logic [COORD_W:0]           cy_s;
  logic [COORD_W:0]           cx_s;
  logic [COORD_W:0]           prev_cy_r;
  logic [COORD_W:0]           prev_cx_r;
  logic                       has_prev_r;
  logic                       near_s;
  logic [3:0]                 cnt_r;
  logic [3:0]                 cnt_nx_s;
`ifdef FRAME_SEQ_CTRL_SMOOTH_EN
  logic                       smooth_ok_r;
`endif

  frame_seq_ctrl_cfg_sync #(.W(6)) u_cfg_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    ({sw_filter_en, sw_rect_en, sw_threshold}),
    .q    (sw_sync_s)
  );

  // vs_d_r resets low, so a fall coincident with reset release cannot be seen
  assign vs_fall_s = vs_d_r & ~vs_ni;
  assign in_s      = {box_t_i, box_b_i, box_l_i, box_r_i};
  assign empty_s   = box_empty(in_s);
  assign load_s    = eval_r & ~empty_s;

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= INIT;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      INIT: begin
        if (vs_fall_s) state_nx_s = RUN;
        else           state_nx_s = INIT;
      end
      RUN:     state_nx_s = RUN;
      default: state_nx_s = INIT;
    endcase
  end

  // frame-boundary config apply, sync strobe, frame counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_d_r      <= 1'b0;
      en_o        <= 1'b0;
      filter_en_o <= 1'b0;
      rect_en_o   <= 1'b0;
      threshold_o <= THRESH_RST;
      sync_o      <= 1'b0;
      eval_r      <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      vs_d_r <= vs_ni;
      en_o   <= (state_nx_s == RUN);
      sync_o <= vs_fall_s;
      eval_r <= vs_fall_s && (state_r == RUN);
      if (vs_fall_s) begin
        filter_en_o <= sw_sync_s[5];
        rect_en_o   <= sw_sync_s[4];
        threshold_o <= sw_sync_s[3:0];
      end
      if (vs_fall_s && (state_r == RUN)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // motion test against the previous non-empty box, always on raw centres
  always_comb begin
    cy_s     = centre(in_s.t, in_s.b);
    cx_s     = centre(in_s.l, in_s.r);
    near_s   = 1'b0;
    cnt_nx_s = 4'd1;
    if (has_prev_r && (abs_diff(cy_s, prev_cy_r) <= TOL_C) &&
        (abs_diff(cx_s, prev_cx_r) <= TOL_C)) begin
      near_s = 1'b1;
    end else begin
      near_s = 1'b0;
    end
    if (near_s) begin
      if (cnt_r == STABLE_C) cnt_nx_s = cnt_r;
      else                   cnt_nx_s = cnt_r + 4'd1;
    end else begin
      cnt_nx_s = 4'd1;
    end
  end

  // value written into the output box register
  always_comb begin
    load_box_s = in_s;
`ifdef FRAME_SEQ_CTRL_SMOOTH_EN
    if (smooth_ok_r) begin
      load_box_s.t = avg_round(box_t, in_s.t);
      load_box_s.b = avg_round(box_b, in_s.b);
      load_box_s.l = avg_round(box_l, in_s.l);
      load_box_s.r = avg_round(box_r, in_s.r);
    end else begin
      load_box_s = in_s;
    end
`endif
  end

`ifdef FRAME_SEQ_CTRL_SMOOTH_EN
  // smoothing only chains across back-to-back non-empty frames
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      smooth_ok_r <= 1'b0;
    end else if (load_s) begin
      smooth_ok_r <= 1'b1;
    end else if (eval_r) begin
      smooth_ok_r <= 1'b0;
    end else begin
      smooth_ok_r <= smooth_ok_r;
    end
  end
`endif

  // box output register, handshake, drop counter and stability
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      box_valid  <= 1'b0;
      box_t      <= {COORD_W{1'b0}};
      box_b      <= {COORD_W{1'b0}};
      box_l      <= {COORD_W{1'b0}};
      box_r      <= {COORD_W{1'b0}};
      box_stable <= 1'b0;
      drop_cnt   <= 8'd0;
      cnt_r      <= 4'd0;
      prev_cy_r  <= {(COORD_W+1){1'b0}};
      prev_cx_r  <= {(COORD_W+1){1'b0}};
      has_prev_r <= 1'b0;
    end else if (load_s) begin
      box_valid  <= 1'b1;
      box_t      <= load_box_s.t;
      box_b      <= load_box_s.b;
      box_l      <= load_box_s.l;
      box_r      <= load_box_s.r;
      box_stable <= (cnt_nx_s == STABLE_C);
      cnt_r      <= cnt_nx_s;
      prev_cy_r  <= cy_s;
      prev_cx_r  <= cx_s;
      has_prev_r <= 1'b1;
      if (box_valid && !box_ready && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else begin
      if (box_valid && box_ready) begin
        box_valid <= 1'b0;
      end
      if (eval_r) begin
        cnt_r      <= 4'd0;
        box_stable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed bench for frame_seq_ctrl with a frame-level reference model checked every cycle.
module tb_frame_seq_ctrl;

  localparam int CW = frame_seq_ctrl_pkg::COORD_W;
`ifdef FRAME_SEQ_CTRL_SMOOTH_EN
  localparam bit SMOOTH = 1'b1;
`else
  localparam bit SMOOTH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          vs_ni = 1'b1;
  logic          sw_filter_en = 1'b0;
  logic          sw_rect_en = 1'b0;
  logic [3:0]    sw_threshold = 4'd3;
  logic          box_ready = 1'b0;
  logic [CW-1:0] bt = 13'd100, bb = 13'd0, bl = 13'd0, br = 13'd0;

  logic          en_o, filter_en_o, rect_en_o, sync_o, box_valid, box_stable;
  logic [3:0]    threshold_o;
  logic [CW-1:0] box_t, box_b, box_l, box_r;
  logic [7:0]    drop_cnt;
  logic [15:0]   frame_cnt;

  int n_chk = 0;
  int n_err = 0;

  frame_seq_ctrl dut (
    .clk(clk), .rstn(rstn), .vs_ni(vs_ni),
    .sw_filter_en(sw_filter_en), .sw_rect_en(sw_rect_en), .sw_threshold(sw_threshold),
    .box_t_i(bt), .box_b_i(bb), .box_l_i(bl), .box_r_i(br),
    .en_o(en_o), .filter_en_o(filter_en_o), .rect_en_o(rect_en_o), .threshold_o(threshold_o),
    .sync_o(sync_o), .box_valid(box_valid), .box_ready(box_ready),
    .box_t(box_t), .box_b(box_b), .box_l(box_l), .box_r(box_r),
    .box_stable(box_stable), .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // ---------------- reference model ----------------
  bit m_run = 0, m_vs_prev = 0, m_eval = 0, m_have_prev = 0, m_have_box = 0, m_fall = 0;
  int m_sw1 = 0, m_sw2 = 0, m_stab = 0, m_pcy = 0, m_pcx = 0;
  int m_t, m_b, m_l, m_r, m_cy, m_cx;
  int e_en = 0, e_filter = 0, e_rect = 0, e_thr = 8, e_sync = 0, e_valid = 0;
  int e_t = 0, e_b = 0, e_l = 0, e_r = 0, e_stable = 0, e_drop = 0, e_frame = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_run = 0; m_vs_prev = 0; m_eval = 0; m_have_prev = 0; m_have_box = 0;
      m_sw1 = 0; m_sw2 = 0; m_stab = 0; m_pcy = 0; m_pcx = 0;
      e_en = 0; e_filter = 0; e_rect = 0; e_thr = 8; e_sync = 0; e_valid = 0;
      e_t = 0; e_b = 0; e_l = 0; e_r = 0; e_stable = 0; e_drop = 0; e_frame = 0;
    end else begin
      m_fall = m_vs_prev && (vs_ni == 1'b0);
      m_t = bt; m_b = bb; m_l = bl; m_r = br;
      if (m_eval) begin
        if (m_t > m_b || m_l > m_r) begin
          m_stab = 0; e_stable = 0; m_have_box = 0;
          if (e_valid != 0 && box_ready) e_valid = 0;
        end else begin
          m_cy = (m_t + m_b) / 2;
          m_cx = (m_l + m_r) / 2;
          if (m_have_prev && iabs(m_cy - m_pcy) <= 8 && iabs(m_cx - m_pcx) <= 8)
            m_stab = (m_stab >= 3) ? 3 : m_stab + 1;
          else
            m_stab = 1;
          m_pcy = m_cy; m_pcx = m_cx; m_have_prev = 1;
          if (e_valid != 0 && !box_ready && e_drop < 255) e_drop++;
          if (SMOOTH && m_have_box) begin
            e_t = (e_t + m_t + 1) / 2; e_b = (e_b + m_b + 1) / 2;
            e_l = (e_l + m_l + 1) / 2; e_r = (e_r + m_r + 1) / 2;
          end else begin
            e_t = m_t; e_b = m_b; e_l = m_l; e_r = m_r;
          end
          m_have_box = 1; e_valid = 1; e_stable = (m_stab == 3);
        end
      end else if (e_valid != 0 && box_ready) begin
        e_valid = 0;
      end
      m_eval = m_fall && m_run;
      e_sync = m_fall;
      if (m_fall) begin
        e_filter = (m_sw2 >> 5) & 1;
        e_rect   = (m_sw2 >> 4) & 1;
        e_thr    = m_sw2 & 15;
        if (m_run) e_frame = (e_frame + 1) % 65536;
        m_run = 1;
      end
      e_en = m_run;
      m_sw2 = m_sw1;
      m_sw1 = {sw_filter_en, sw_rect_en, sw_threshold};
      m_vs_prev = vs_ni;
    end
  end

  // per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("en_o", en_o, e_en);
    chk("filter_en_o", filter_en_o, e_filter);
    chk("rect_en_o", rect_en_o, e_rect);
    chk("threshold_o", threshold_o, e_thr);
    chk("sync_o", sync_o, e_sync);
    chk("box_valid", box_valid, e_valid);
    chk("box_t", box_t, e_t);
    chk("box_b", box_b, e_b);
    chk("box_l", box_l, e_l);
    chk("box_r", box_r, e_r);
    chk("box_stable", box_stable, e_stable);
    chk("drop_cnt", drop_cnt, e_drop);
    chk("frame_cnt", frame_cnt, e_frame);
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fall_to_sync();  // returns in the cycle sync_o is high
    @(negedge clk);
    vs_ni = 1'b0;
    @(negedge clk);
  endtask

  task automatic sync_to_box();   // returns in the cycle a loaded box is visible
    @(negedge clk);
    vs_ni = 1'b1;
  endtask

  task automatic set_box(input int t, input int b, input int l, input int r);
    bt = t[CW-1:0]; bb = b[CW-1:0]; bl = l[CW-1:0]; br = r[CW-1:0];
  endtask

  task automatic frame();
    fall_to_sync();
    sync_to_box();
  endtask

  initial begin
    #1 rstn = 1'b0;
    idle(3);
    chk("rst_en", en_o, 0);
    chk("rst_thr", threshold_o, 8);
    chk("rst_valid", box_valid, 0);
    chk("rst_sync", sync_o, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_frame", frame_cnt, 0);
    chk("rst_stable", box_stable, 0);
    rstn = 1'b1;
    idle(5);
    chk("thr_hold", threshold_o, 8);
    chk("en_pre", en_o, 0);
    fall_to_sync();
    chk("thr_applied", threshold_o, 3);
    chk("en_rise", en_o, 1);
    chk("sync_pulse", sync_o, 1);
    sync_to_box();
    chk("sync_once", sync_o, 0);
    chk("frame_first", frame_cnt, 0);
    idle(6);

    sw_filter_en = 1'b1; sw_rect_en = 1'b1;
    idle(8);
    chk("filter_hold", filter_en_o, 0);
    fall_to_sync();
    chk("filter_apply", filter_en_o, 1);
    chk("rect_apply", rect_en_o, 1);
    sync_to_box();
    chk("empty_no_load", box_valid, 0);
    idle(6);

    set_box(10, 50, 20, 80); box_ready = 1'b1;
    fall_to_sync();
    chk("valid_lat1", box_valid, 0);
    sync_to_box();
    chk("valid_lat2", box_valid, 1);
    chk("cap_t", box_t, 10);
    chk("cap_b", box_b, 50);
    chk("cap_l", box_l, 20);
    chk("cap_r", box_r, 80);
    idle(1);
    chk("valid_accept", box_valid, 0);
    idle(5);
    chk("frame_two", frame_cnt, 2);

    box_ready = 1'b0;
    set_box(10, 50, 20, 80);    frame(); idle(5);
    set_box(200, 300, 200, 300); frame(); idle(5);
    set_box(400, 500, 400, 500); frame();
    chk("drop_two", drop_cnt, 2);
    chk("hold_third", box_t, SMOOTH ? 253 : 400);
    chk("valid_held", box_valid, 1);
    idle(3);
    box_ready = 1'b1;
    idle(1);
    chk("valid_drain", box_valid, 0);
    chk("frame_five", frame_cnt, 5);
    idle(4);

    set_box(100, 0, 0, 0); frame();
    chk("empty_unstable", box_stable, 0);
    chk("empty_invalid", box_valid, 0);
    idle(5);
    set_box(100, 120, 100, 140); frame();
    chk("stab_1", box_stable, 0);
    idle(5);
    set_box(105, 125, 105, 145); frame();
    chk("stab_2", box_stable, 0);
    idle(5);
    set_box(110, 130, 110, 150); frame();
    chk("stab_3", box_stable, 1);
    idle(5);

    set_box(100, 0, 0, 0); frame(); idle(5);
    set_box(0, 10, 0, 10); frame();
    chk("smooth_first", box_l, 0);
    idle(5);
    set_box(0, 10, 100, 110); frame();
    chk("smooth_second", box_l, SMOOTH ? 50 : 100);
    chk("frame_end", frame_cnt, 12);
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
